// File: rtl/load_store_unit_if.sv
// Core-request, data-memory and response signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the core/memory side.
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_wstrb;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_misaligned;
  logic             resp_fault;
  logic             busy;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rdata, resp_misaligned, resp_fault, busy
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rdata, resp_misaligned, resp_fault, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one access at a time over a valid/ack memory port,
// with byte-lane steering, load extension, misalignment/illegal-funct3 and timeout reporting.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  load_store_unit_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] C_TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t           r_state, w_state_next;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [3:0]       r_mem_wstrb;
  logic [2:0]       r_funct3;
  logic [1:0]       r_addr_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_misaligned;
  logic             r_fault;

  logic             w_accept, w_illegal, w_misaligned, w_ack, w_timeout;
  logic [3:0]       w_strb;
  logic [WIDTH-1:0] w_wdata, w_shift, w_load_data;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_ack    = (r_state == S_WAIT) && bus.mem_ack;
  // ack in the same cycle as the final count takes priority over the timeout
  assign w_timeout = (TIMEOUT != 0) && (r_state == S_WAIT) && !bus.mem_ack && (r_cnt == C_TO_LAST);

  always_comb begin
    w_illegal = 1'b1;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = bus.req_we;
      default:                w_illegal = 1'b1;
    endcase
  end

  assign w_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    w_strb  = 4'hF;
    w_wdata = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << bus.req_addr[1:0];
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_strb  = 4'hF;
        w_wdata = bus.req_wdata;
      end
    endcase
    if (!bus.req_we) w_strb = 4'h0;
  end

  assign w_shift = bus.mem_rdata >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_data = w_shift;
    case (r_funct3)
      3'b000:  w_load_data = {{(WIDTH-8){w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_data = {{(WIDTH-16){w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_data = {{(WIDTH-8){1'b0}}, w_shift[7:0]};
      3'b101:  w_load_data = {{(WIDTH-16){1'b0}}, w_shift[15:0]};
      default: w_load_data = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (w_illegal || w_misaligned) ? S_RESP : S_WAIT;
      S_WAIT:  if (w_ack || w_timeout) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wstrb  <= 4'h0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_fault      <= 1'b0;
    end else if (w_accept) begin
      r_funct3     <= bus.req_funct3;
      r_addr_lo    <= bus.req_addr[1:0];
      r_fault      <= w_illegal;
      r_misaligned <= !w_illegal && w_misaligned;
      r_rdata      <= '0;
      r_cnt        <= '0;
      if (!w_illegal && !w_misaligned) begin
        r_mem_we    <= bus.req_we;
        r_mem_addr  <= {bus.req_addr[WIDTH-1:2], 2'b00};
        r_mem_wstrb <= w_strb;
        r_mem_wdata <= w_wdata;
      end
    end else if (r_state == S_WAIT) begin
      if (bus.mem_ack) begin
        if (!r_mem_we) r_rdata <= w_load_data;
      end else if (w_timeout) begin
        r_fault <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready       = (r_state == S_IDLE);
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.mem_req         = (r_state == S_WAIT);
  assign bus.mem_we          = r_mem_we;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wstrb       = r_mem_wstrb;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.resp_valid      = (r_state == S_RESP);
  assign bus.resp_rdata      = (r_state == S_RESP) ? r_rdata : '0;
  assign bus.resp_misaligned = (r_state == S_RESP) && r_misaligned;
  assign bus.resp_fault      = (r_state == S_RESP) && r_fault;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (TIMEOUT=4): loads, stores, errors,
// timeout, mid-access reset and held-request back-to-back behaviour.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        fault;
  } exp_t;
  exp_t sb[$];

  load_store_unit_if #(.WIDTH(32)) bus();

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0]  LD_F3   [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
  localparam logic [31:0] LD_ADDR [6] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
  localparam logic [31:0] LD_WORD [6] = '{32'hDEADBEEF, 32'h80123456, 32'h80123456,
                                          32'h80123456, 32'h80123456, 32'h80123456};
  localparam logic [31:0] LD_EXP  [6] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080,
                                          32'hFFFF8012, 32'h00008012, 32'h00000034};
  localparam int          LD_DLY  [6] = '{1, 2, 3, 4, 1, 2};

  localparam logic [2:0]  ST_F3    [3] = '{3'b001, 3'b000, 3'b010};
  localparam logic [31:0] ST_ADDR  [3] = '{32'h202, 32'h201, 32'h30C};
  localparam logic [31:0] ST_DATA  [3] = '{32'h0000ABCD, 32'h12345678, 32'hCAFEF00D};
  localparam logic [31:0] ST_MADDR [3] = '{32'h200, 32'h200, 32'h30C};
  localparam logic [3:0]  ST_STRB  [3] = '{4'b1100, 4'b0010, 4'b1111};
  localparam logic [31:0] ST_WDATA [3] = '{32'hABCDABCD, 32'h78787878, 32'hCAFEF00D};

  localparam logic        ER_WE   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [2:0]  ER_F3   [6] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b110, 3'b010};
  localparam logic [31:0] ER_ADDR [6] = '{32'h101, 32'h100, 32'h103, 32'h200, 32'h101, 32'h202};
  localparam logic        ER_MIS  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic        ER_FLT  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // Presents a request for one cycle; returns at the falling edge after the accept edge.
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic ack_after(input int n, input logic [31:0] word);
    for (int k = 1; k < n; k++) @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = word;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  endtask

  task automatic wait_resp(output bit got, output int cyc, output logic [31:0] rd,
                           output logic mis, output logic flt);
    got = 1'b0; cyc = 0; rd = '0; mis = 1'b0; flt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1; cyc = i;
        rd = bus.resp_rdata; mis = bus.resp_misaligned; flt = bus.resp_fault;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req !== 1'b0 ||
        bus.resp_valid !== 1'b0 || bus.mem_wstrb !== 4'h0 || bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset: ready=%b busy=%b mem_req=%b resp_valid=%b wstrb=%h rdata=%h required 1 0 0 0 0 0",
               bus.req_ready, bus.busy, bus.mem_req, bus.resp_valid, bus.mem_wstrb, bus.resp_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loads;
    bit got; int cyc; logic [31:0] rd; logic mis, flt; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: LD_EXP[i], mis: 1'b0, fault: 1'b0});
      drive_req(1'b0, LD_F3[i], LD_ADDR[i], 32'h0);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0 ||
          bus.mem_addr !== {LD_ADDR[i][31:2], 2'b00}) begin
        failures++;
        $display("FAIL load_bus[%0d]: req=%b we=%b strb=%h addr=%h required 1 0 0 %h",
                 i, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, {LD_ADDR[i][31:2], 2'b00});
      end
      ack_after(LD_DLY[i], LD_WORD[i]);
      wait_resp(got, cyc, rd, mis, flt);
      e = sb.pop_front();
      checks++;
      if (!got || cyc != 0 || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
        failures++;
        $display("FAIL load_resp[%0d]: got=%0b cyc=%0d rdata=%h mis=%b fault=%b required rdata=%h mis=%b fault=%b",
                 i, got, cyc, rd, mis, flt, e.rdata, e.mis, e.fault);
      end
      $display("load f3=%b addr=%h word=%h -> rdata=%h", LD_F3[i], LD_ADDR[i], LD_WORD[i], rd);
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL load_pulse[%0d]: resp_valid=%b ready=%b required 0 1", i, bus.resp_valid, bus.req_ready);
      end
    end
  endtask

  task automatic test_stores;
    bit got; int cyc; logic [31:0] rd; logic mis, flt; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'h0, mis: 1'b0, fault: 1'b0});
      drive_req(1'b1, ST_F3[i], ST_ADDR[i], ST_DATA[i]);
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== ST_MADDR[i] ||
          bus.mem_wstrb !== ST_STRB[i] || bus.mem_wdata !== ST_WDATA[i]) begin
        failures++;
        $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h strb=%b wdata=%h required 1 1 %h %b %h",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata,
                 ST_MADDR[i], ST_STRB[i], ST_WDATA[i]);
      end
      ack_after(i + 1, 32'hFFFFFFFF);
      wait_resp(got, cyc, rd, mis, flt);
      e = sb.pop_front();
      checks++;
      if (!got || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
        failures++;
        $display("FAIL store_resp[%0d]: got=%0b rdata=%h mis=%b fault=%b required rdata=%h mis=%b fault=%b",
                 i, got, rd, mis, flt, e.rdata, e.mis, e.fault);
      end
      $display("store f3=%b addr=%h data=%h -> strb=%b", ST_F3[i], ST_ADDR[i], ST_DATA[i], ST_STRB[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_errors;
    bit got; int cyc; logic [31:0] rd; logic mis, flt; exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: 32'h0, mis: ER_MIS[i], fault: ER_FLT[i]});
      drive_req(ER_WE[i], ER_F3[i], ER_ADDR[i], 32'h5555AAAA);
      checks++;
      if (bus.mem_req !== 1'b0) begin
        failures++;
        $display("FAIL err_no_mem[%0d]: mem_req=%b required 0", i, bus.mem_req);
      end
      wait_resp(got, cyc, rd, mis, flt);
      e = sb.pop_front();
      checks++;
      if (!got || cyc != 0 || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
        failures++;
        $display("FAIL err_resp[%0d]: got=%0b cyc=%0d rdata=%h mis=%b fault=%b required rdata=%h mis=%b fault=%b",
                 i, got, cyc, rd, mis, flt, e.rdata, e.mis, e.fault);
      end
      $display("error we=%b f3=%b addr=%h -> mis=%b fault=%b", ER_WE[i], ER_F3[i], ER_ADDR[i], mis, flt);
      @(negedge clk);
    end
  endtask

  task automatic test_timeout;
    bit got; int cyc; int high; logic [31:0] rd; logic mis, flt; exp_t e;
    sb.push_back('{rdata: 32'h0, mis: 1'b0, fault: 1'b1});
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    high = 0;
    while (bus.mem_req === 1'b1 && high < 10) begin
      high++;
      @(negedge clk);
    end
    checks++;
    if (high != 4) begin
      failures++;
      $display("FAIL timeout_len: mem_req high %0d cycles required 4", high);
    end
    wait_resp(got, cyc, rd, mis, flt);
    e = sb.pop_front();
    checks++;
    if (!got || cyc != 0 || bus.mem_req !== 1'b0 || rd !== e.rdata || flt !== e.fault || mis !== e.mis) begin
      failures++;
      $display("FAIL timeout_resp: got=%0b cyc=%0d mem_req=%b rdata=%h fault=%b mis=%b required fault=1 mis=0 rdata=0",
               got, cyc, bus.mem_req, rd, flt, mis);
    end
    $display("timeout LW 0x100 -> fault=%b after %0d request cycles", flt, high);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stray_ack: resp_valid=%b busy=%b required 0 0", bus.resp_valid, bus.busy);
    end
    bus.mem_ack = 1'b0;
    sb.push_back('{rdata: 32'h13572468, mis: 1'b0, fault: 1'b0});
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    ack_after(4, 32'h13572468);
    wait_resp(got, cyc, rd, mis, flt);
    e = sb.pop_front();
    checks++;
    if (!got || cyc != 0 || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
      failures++;
      $display("FAIL ack_at_limit: got=%0b cyc=%0d rdata=%h fault=%b required rdata=%h fault=0",
               got, cyc, rd, flt, e.rdata);
    end
    $display("ack on 4th wait cycle -> rdata=%h fault=%b", rd, flt);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit got; int cyc; int seen; logic [31:0] rd; logic mis, flt; exp_t e;
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: mem_req=%b busy=%b resp_valid=%b required 0 0 0",
               bus.mem_req, bus.busy, bus.resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.resp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_abandon: responses=%0d ready=%b required 0 1", seen, bus.req_ready);
    end
    sb.push_back('{rdata: 32'h11223344, mis: 1'b0, fault: 1'b0});
    drive_req(1'b0, 3'b010, 32'h104, 32'h0);
    ack_after(1, 32'h11223344);
    wait_resp(got, cyc, rd, mis, flt);
    e = sb.pop_front();
    checks++;
    if (!got || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
      failures++;
      $display("FAIL reset_recover: got=%0b rdata=%h mis=%b fault=%b required rdata=%h", got, rd, mis, flt, e.rdata);
    end
    $display("after reset LW 0x104 -> rdata=%h", rd);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit got; int cyc; logic [31:0] rd; logic mis, flt; exp_t e;
    sb.push_back('{rdata: 32'hA5A5A5A5, mis: 1'b0, fault: 1'b0});
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h0;
    @(negedge clk);
    bus.req_addr = 32'h400;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1 || bus.mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL b2b_hold: ready=%b busy=%b addr=%h required 0 1 00000100",
               bus.req_ready, bus.busy, bus.mem_addr);
    end
    ack_after(1, 32'hA5A5A5A5);
    wait_resp(got, cyc, rd, mis, flt);
    e = sb.pop_front();
    checks++;
    if (!got || bus.req_ready !== 1'b0 || rd !== e.rdata || flt !== e.fault || mis !== e.mis) begin
      failures++;
      $display("FAIL b2b_first: got=%0b ready=%b rdata=%h required rdata=%h ready=0", got, bus.req_ready, rd, e.rdata);
    end
    $display("b2b first LW 0x100 -> rdata=%h", rd);
    sb.push_back('{rdata: 32'h0F0F0F0F, mis: 1'b0, fault: 1'b0});
    @(negedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400) begin
      failures++;
      $display("FAIL b2b_second_bus: mem_req=%b addr=%h required 1 00000400", bus.mem_req, bus.mem_addr);
    end
    ack_after(2, 32'h0F0F0F0F);
    wait_resp(got, cyc, rd, mis, flt);
    e = sb.pop_front();
    checks++;
    if (!got || rd !== e.rdata || mis !== e.mis || flt !== e.fault) begin
      failures++;
      $display("FAIL b2b_second: got=%0b rdata=%h required %h", got, rd, e.rdata);
    end
    $display("b2b second LW 0x400 -> rdata=%h", rd);
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
